// File: rtl/reg_file_wr_demux.sv
// rtl/reg_file_wr_demux.sv - ARM register file with demuxed write port and bypassed read ports
module reg_file_wr_demux #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              wr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic             wb_oor;
  logic             wr_err_q;
  logic             wr_err_d;

  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wr_sel[k] = wb_en && (wb_addr == ADDR_W'(k));
    end
    wb_oor = wb_en && ({1'b0, wb_addr} >= DEPTH_L);
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      regs_d[k] = wr_sel[k] ? wb_data : regs_q[k];
    end
    wr_err_d = wr_err_q | wb_oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
      wr_err_q <= wr_err_d;
    end
  end

  // Out-of-range read addresses match no register and fall through to 0;
  // bypass rides on wr_sel, so it can only hit an in-range target.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rd_addr1 == ADDR_W'(k)) rd_data1 = wr_sel[k] ? wb_data : regs_q[k];
        if (rd_addr2 == ADDR_W'(k)) rd_data2 = wr_sel[k] ? wb_data : regs_q[k];
      end
    end
  end

  assign wr_err = wr_err_q;

endmodule

// File: doc/reg_file_wr_demux.md
Name: reg_file_wr_demux

Overview:
- Register file for the ARM core. Central feature is the write side: one write port demultiplexes a single data word onto one of DEPTH storage registers.
- Two read ports select stored registers by address. Each read port has write-to-read bypass, so a value written in cycle N is visible on the same-cycle read.
- Sits between the decode stage (reads Rn/Rm) and the write-back stage (writes Rd).

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 15, number of architectural registers (R0-R14); R15/PC is held outside the block.
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  clock; state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- wb_en  input  1  write enable from write-back.
- wb_addr  input  ADDR_W  destination register index.
- wb_data  input  WIDTH  write data.
- rd_addr1  input  ADDR_W  read port 1 index (Rn).
- rd_addr2  input  ADDR_W  read port 2 index (Rm).
- rd_data1  output  WIDTH  read port 1 data.
- rd_data2  output  WIDTH  read port 2 data.
- wr_err  output  1  registered flag: an out-of-range write was attempted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All DEPTH registers clear to 0.
  - wr_err clears to 0.
  - Read outputs follow the cleared contents combinationally, so they read 0 for in-range addresses.
- Write path:
  - The write decoder produces a one-hot enable: bit k = wb_en & (wb_addr == k), for k in 0..DEPTH-1.
  - On a rising clk edge, register k loads wb_data when its enable bit is 1. All other registers hold.
  - At most one register is written per cycle.
- Out-of-range write (wb_en=1 and wb_addr >= DEPTH):
  - No register changes.
  - wr_err is set to 1 on that edge and stays 1 (sticky) until reset.
- Read path is combinational, with no clock latency.
- Bypass:
  - When wb_en=1, wb_addr < DEPTH and rd_addrX == wb_addr, rd_dataX = wb_data in the same cycle.
  - Otherwise rd_dataX = the stored register contents.
  - Both ports bypass independently. When both ports address the write target, both return wb_data.
- Out-of-range read (rd_addrX >= DEPTH) returns 0. There is no bypass in this case, even if a write to the same out-of-range index is attempted.
- Write latency is 1 cycle to storage and 0 cycles to the read ports through the bypass.
- Reset mid-operation:
  - Asserting rst_n low overrides any pending write in the same cycle.
  - While rst_n is low, the bypass is disabled and all read outputs are 0 for every address.
- Deassertion of rst_n is released synchronously to clk by the top-level reset synchronizer. The block itself adds no synchronizer.
- wb_en=0: no state changes; read outputs are pure storage reads.

Test Plan:
- Reset:
  - Stimulus: drive rst_n=0 asynchronously mid-cycle, after R3 holds 0xDEADBEEF.
  - Response: rd_data1 for addr 3 reads 0 immediately without waiting for a clock edge; wr_err=0.
- Write then read:
  - Stimulus: wb_en=1, wb_addr=5, wb_data=0x12345678; clock once; then wb_en=0, rd_addr1=5, rd_addr2=4.
  - Response: rd_data1=0x12345678, rd_data2=0.
- Same-cycle bypass:
  - Stimulus: R7 holds 0x11; drive wb_en=1, wb_addr=7, wb_data=0xAA, rd_addr1=7, rd_addr2=7.
  - Response: both ports read 0xAA before the edge; after the edge R7 stores 0xAA.
- Decoder one-hot check:
  - Stimulus: write 0x100+k to each Rk, k=0..14.
  - Response: each read returns its own value, with no aliasing between registers.
- Out-of-range write:
  - Stimulus: wb_en=1, wb_addr=15, wb_data=0xFFFF.
  - Response: all R0-R14 are unchanged; wr_err=1 after the edge and still 1 ten cycles later; rd_data1 for addr 15 reads 0.
- Reset during write:
  - Stimulus: wb_en=1, wb_addr=2, wb_data=0x55, with rst_n low across the edge.
  - Response: R2 stays 0.
